// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: command codes, scancodes,
// prefix bytes, receiver states and the make-code lookup.
package ps2_pkg;

    localparam logic [3:0] CMD_NUM0   = 4'h0;
    localparam logic [3:0] CMD_NUM1   = 4'h1;
    localparam logic [3:0] CMD_NUM2   = 4'h2;
    localparam logic [3:0] CMD_NUM3   = 4'h3;
    localparam logic [3:0] CMD_RED    = 4'h4;
    localparam logic [3:0] CMD_GREEN  = 4'h5;
    localparam logic [3:0] CMD_BLUE   = 4'h6;
    localparam logic [3:0] CMD_UP     = 4'h7;
    localparam logic [3:0] CMD_DOWN   = 4'h8;
    localparam logic [3:0] CMD_LEFT   = 4'h9;
    localparam logic [3:0] CMD_RIGHT  = 4'hA;
    localparam logic [3:0] CMD_FASTER = 4'hB;
    localparam logic [3:0] CMD_SLOWER = 4'hC;
    localparam logic [3:0] CMD_BG     = 4'hD;
    localparam logic [3:0] CMD_FLASH  = 4'hE;
    localparam logic [3:0] CMD_NONE   = 4'hF;

    localparam logic [7:0] SC_NUM0    = 8'h45;
    localparam logic [7:0] SC_NUM1    = 8'h16;
    localparam logic [7:0] SC_NUM2    = 8'h1E;
    localparam logic [7:0] SC_NUM3    = 8'h26;
    localparam logic [7:0] SC_R       = 8'h2D;
    localparam logic [7:0] SC_G       = 8'h34;
    localparam logic [7:0] SC_B       = 8'h32;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_KPPLUS  = 8'h79;
    localparam logic [7:0] SC_KPMINUS = 8'h7B;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_F       = 8'h2B;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rxState_t;

    // Extended and plain codes live in separate tables; a code never maps in both.
    function automatic logic [3:0] mapCode(input logic ext, input logic [7:0] sc);
        logic [3:0] cmd;
        cmd = CMD_NONE;
        if (ext) begin
            case (sc)
                SC_UP:    cmd = CMD_UP;
                SC_DOWN:  cmd = CMD_DOWN;
                SC_LEFT:  cmd = CMD_LEFT;
                SC_RIGHT: cmd = CMD_RIGHT;
                default:  cmd = CMD_NONE;
            endcase
        end else begin
            case (sc)
                SC_NUM0:    cmd = CMD_NUM0;
                SC_NUM1:    cmd = CMD_NUM1;
                SC_NUM2:    cmd = CMD_NUM2;
                SC_NUM3:    cmd = CMD_NUM3;
                SC_R:       cmd = CMD_RED;
                SC_G:       cmd = CMD_GREEN;
                SC_B:       cmd = CMD_BLUE;
                SC_KPPLUS:  cmd = CMD_FASTER;
                SC_KPMINUS: cmd = CMD_SLOWER;
                SC_SPACE:   cmd = CMD_BG;
                SC_F:       cmd = CMD_FLASH;
                default:    cmd = CMD_NONE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, framing FSM
// with odd-parity and stop checks, and an inactivity timeout.
module ps2_rx import ps2_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       rxErr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clkSync;
    logic [1:0]    dataSync;
    logic          clkPrev;
    logic          fallEdge;
    logic          dataBit;
    rxState_t      state;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          parityBit;
    logic [TW-1:0] toCnt;

    // Synchronisers reset high so release never fakes a falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clkSync  <= '1;
            dataSync <= '1;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
            clkPrev  <= clkSync[1];
        end
    end

    assign fallEdge = clkPrev & ~clkSync[1];
    assign dataBit  = dataSync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RX_IDLE;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            toCnt     <= '0;
            rxByte    <= '0;
            rxValid   <= 1'b0;
            rxErr     <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            rxErr   <= 1'b0;
            if (fallEdge) begin
                toCnt <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!dataBit) begin
                            state  <= RX_DATA;
                            bitCnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shiftReg <= {dataBit, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parityBit <= dataBit;
                        state     <= RX_STOP;
                    end
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if ((^{shiftReg, parityBit}) && dataBit) begin
                            rxByte  <= shiftReg;
                            rxValid <= 1'b1;
                        end else begin
                            rxErr <= 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE) begin
                // Abort on the edge that would bring the count to TIMEOUT_CYCLES.
                if (toCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state <= RX_IDLE;
                    rxErr <= 1'b1;
                    toCnt <= '0;
                end else begin
                    toCnt <= toCnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: tracks E0/F0 prefixes and turns accepted make
// codes into single-cycle commands for the input decoder.
module ps2_key_decoder import ps2_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [3:0] inCode,
    output logic       codeValid,
    output logic       frameErr
);

    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxErr;
    logic       ext;
    logic       brk;
    logic [3:0] mapped;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) rxInst (
        .clock   (clock),
        .reset   (reset),
        .ps2Clk  (ps2Clk),
        .ps2Data (ps2Data),
        .rxByte  (rxByte),
        .rxValid (rxValid),
        .rxErr   (rxErr)
    );

    always_comb begin
        mapped = mapCode(ext, rxByte);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inCode    <= CMD_NONE;
            codeValid <= 1'b0;
            frameErr  <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            inCode    <= CMD_NONE;
            codeValid <= 1'b0;
            frameErr  <= rxErr;
            if (rxErr) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rxValid) begin
                if (rxByte == PFX_EXT) begin
                    ext <= 1'b1;
                end else if (rxByte == PFX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!brk && mapped != CMD_NONE) begin
                        inCode    <= mapped;
                        codeValid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed and random PS/2 frames checked against
// a byte-level prefix/lookup model and a recorded log of emitted commands.
module tb_ps2_key_decoder;

    localparam int unsigned TO   = 100;
    localparam int unsigned HALF = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2Clk = 1'b1;
    logic       ps2Data = 1'b1;
    logic [3:0] inCode;
    logic       codeValid;
    logic       frameErr;

    int errors = 0;
    int checks = 0;

    logic [3:0] keyMap [logic [8:0]];
    logic       refExt = 1'b0;
    logic       refBrk = 1'b0;
    logic [3:0] expCodes [$];
    logic [3:0] gotCodes [$];
    int         expErrs = 0;
    int         gotErrs = 0;
    int         cvBad = 0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .inCode    (inCode),
        .codeValid (codeValid),
        .frameErr  (frameErr)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (reset) begin
            if (codeValid) gotCodes.push_back(inCode);
            if (frameErr) gotErrs++;
            if (codeValid !== (inCode != 4'hF)) cvBad++;
        end
    end

    // Byte-level model: returns the expected command (4'hF for none).
    function automatic logic [3:0] modelByte(input logic [7:0] b, input logic err);
        logic [3:0] res;
        res = 4'hF;
        if (err) begin
            refExt = 1'b0;
            refBrk = 1'b0;
        end else if (b == 8'hE0) begin
            refExt = 1'b1;
        end else if (b == 8'hF0) begin
            refBrk = 1'b1;
        end else begin
            if (!refBrk && keyMap.exists({refExt, b})) res = keyMap[{refExt, b}];
            refExt = 1'b0;
            refBrk = 1'b0;
        end
        return res;
    endfunction

    task automatic ps2Bit(input logic b);
        @(negedge clock);
        ps2Data = b;
        repeat (HALF) @(negedge clock);
        ps2Clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2Clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic badStop);
        logic       err;
        logic [3:0] exp;
        err = badPar | badStop;
        exp = modelByte(b, err);
        if (exp != 4'hF) expCodes.push_back(exp);
        if (err) expErrs++;
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(b[i]);
        ps2Bit(badPar ? (^b) : ~(^b));
        @(negedge clock);
        ps2Data = ~badStop;
        repeat (HALF) @(negedge clock);
        ps2Clk = 1'b0;
        repeat (3) @(posedge clock);
        #1 checkEq("preIdle", {inCode, codeValid, frameErr}, {4'hF, 1'b0, 1'b0});
        @(posedge clock);
        #1 checkEq("emit", {inCode, codeValid, frameErr}, {exp, exp != 4'hF, err});
        @(posedge clock);
        #1 checkEq("revert", {inCode, codeValid, frameErr}, {4'hF, 1'b0, 1'b0});
        repeat (HALF - 5) @(negedge clock);
        ps2Clk = 1'b1;
        ps2Data = 1'b1;
        repeat (20) @(negedge clock);
    endtask

    task automatic sendPartial(input logic [7:0] b, input int nBits);
        ps2Bit(1'b0);
        for (int i = 0; i < nBits; i++) ps2Bit(b[i]);
    endtask

    initial begin
        logic [7:0] pool [15];
        logic       seen;
        int         waited;
        int         n;

        keyMap[{1'b0, 8'h45}] = 4'h0; keyMap[{1'b0, 8'h16}] = 4'h1;
        keyMap[{1'b0, 8'h1E}] = 4'h2; keyMap[{1'b0, 8'h26}] = 4'h3;
        keyMap[{1'b0, 8'h2D}] = 4'h4; keyMap[{1'b0, 8'h34}] = 4'h5;
        keyMap[{1'b0, 8'h32}] = 4'h6; keyMap[{1'b1, 8'h75}] = 4'h7;
        keyMap[{1'b1, 8'h72}] = 4'h8; keyMap[{1'b1, 8'h6B}] = 4'h9;
        keyMap[{1'b1, 8'h74}] = 4'hA; keyMap[{1'b0, 8'h79}] = 4'hB;
        keyMap[{1'b0, 8'h7B}] = 4'hC; keyMap[{1'b0, 8'h29}] = 4'hD;
        keyMap[{1'b0, 8'h2B}] = 4'hE;
        pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h2D, 8'h34, 8'h32, 8'h75,
                 8'h72, 8'h6B, 8'h74, 8'h79, 8'h7B, 8'h29, 8'h2B};

        repeat (4) @(posedge clock);
        #1 checkEq("resetState", {inCode, codeValid, frameErr}, {4'hF, 1'b0, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        sendFrame(8'h45, 1'b0, 1'b0);
        sendFrame(8'hE0, 1'b0, 1'b0);
        sendFrame(8'h75, 1'b0, 1'b0);
        sendFrame(8'hE0, 1'b0, 1'b0);
        sendFrame(8'hF0, 1'b0, 1'b0);
        sendFrame(8'h75, 1'b0, 1'b0);
        sendFrame(8'h75, 1'b0, 1'b0);
        sendFrame(8'hE0, 1'b0, 1'b0);
        sendFrame(8'h45, 1'b0, 1'b0);
        sendFrame(8'h2B, 1'b1, 1'b0);
        sendFrame(8'h2B, 1'b0, 1'b0);
        sendFrame(8'hE0, 1'b0, 1'b0);
        sendFrame(8'h72, 1'b0, 1'b1);
        sendFrame(8'h72, 1'b0, 1'b0);

        // Timeout mid-frame also drops a pending E0.
        sendFrame(8'hE0, 1'b0, 1'b0);
        sendPartial(8'h2B, 5);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < int'(TO + 4 * HALF)) begin
            @(posedge clock);
            #1;
            if (frameErr) seen = 1'b1;
            else waited++;
        end
        checkEq("timeoutErr", 32'(seen), 32'd1);
        checkEq("timeoutLate", 32'(waited >= int'(TO - 2 * HALF)), 32'd1);
        expErrs++;
        refExt = 1'b0;
        refBrk = 1'b0;
        ps2Data = 1'b1;
        repeat (20) @(negedge clock);
        sendFrame(8'h75, 1'b0, 1'b0);
        sendFrame(8'h29, 1'b0, 1'b0);

        // Reset mid-frame after 0x16's fourth data bit.
        sendFrame(8'hF0, 1'b0, 1'b0);
        sendPartial(8'h16, 4);
        @(negedge clock);
        reset = 1'b0;
        refExt = 1'b0;
        refBrk = 1'b0;
        repeat (3) @(posedge clock);
        #1 checkEq("midReset", {inCode, codeValid, frameErr}, {4'hF, 1'b0, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        ps2Data = 1'b1;
        repeat (10) @(negedge clock);
        sendFrame(8'h1E, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) sendFrame(8'h79, 1'b0, 1'b0);

        for (int i = 0; i < 70; i++) begin
            logic [7:0] b;
            n = int'($urandom_range(0, 9));
            if (n <= 5) b = pool[$urandom_range(0, 14)];
            else if (n == 6) b = 8'hE0;
            else if (n == 7) b = 8'hF0;
            else b = 8'($urandom);
            sendFrame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
        end

        repeat (10) @(posedge clock);
        checkEq("errCount", 32'(gotErrs), 32'(expErrs));
        checkEq("cvConsistent", 32'(cvBad), 32'd0);
        checkEq("emitCount", 32'(gotCodes.size()), 32'(expCodes.size()));
        n = (gotCodes.size() < expCodes.size()) ? gotCodes.size() : expCodes.size();
        for (int i = 0; i < n; i++) checkEq("emitSeq", 32'(gotCodes[i]), 32'(expCodes[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
